// File: rtl/game_pkg.sv
// Shared constants and types for the board move sequencer.
package game_pkg;

  localparam int unsigned CELLS = 16;
  localparam int unsigned SUM_W = 20;

  localparam logic [3:0] TILE_2 = 4'd1;
  localparam logic [3:0] TILE_4 = 4'd2;

  localparam logic [3:0] DIR_LEFT  = 4'b0001;
  localparam logic [3:0] DIR_RIGHT = 4'b0010;
  localparam logic [3:0] DIR_UP    = 4'b0100;
  localparam logic [3:0] DIR_DOWN  = 4'b1000;

  typedef enum logic [3:0] {
    ST_INIT_A,
    ST_INIT_B,
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_SETTLE,
    ST_SCAN,
    ST_WRITE,
    ST_CHECK,
    ST_OVER
  } state_t;

  // Exponent of cell i from the packed row-major board.
  function automatic logic [3:0] cell_val(input logic [63:0] b, input logic [3:0] i);
    return b[4*i +: 4];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11, free-running.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic        w_fb;

  assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];

  // Shift one step every cycle; reset loads the nonzero seed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_q <= SEED;
    else      r_q <= {r_q[14:0], w_fb};
  end

  assign q = r_q;

endmodule

// File: rtl/move_sequencer.sv
// Board-level move controller: launch, settle, score, spawn, game-over.
module move_sequencer
  import game_pkg::*;
#(
  parameter int unsigned SCORE_W   = 20,
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [3:0]         key_dir,
  output logic               key_accept,
  output logic [3:0]         launch_dir,
  input  logic [3:0]         line_done,
  input  logic [63:0]        board_values,
  input  logic [15:0]        node_score,
  input  logic [15:0]        node_movable,
  output logic [15:0]        preset_ext,
  output logic [3:0]         preset_value,
  output logic [SCORE_W-1:0] score_total,
  output logic               busy,
  output logic               game_over,
  output logic               err
);

  localparam int unsigned TW     = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  state_t              r_state, w_next, r_ret;
  logic [63:0]         r_snap;
  logic [3:0]          r_dir, r_mask, w_mask;
  logic [TW-1:0]       r_timer;
  logic [3:0]          r_start, r_k, r_idx, w_scan_idx;
  logic                w_scan_hit, w_key_ok;
  logic [SCORE_W-1:0]  r_score;
  logic [SUM_W-1:0]    w_sum;
  logic [SCORE_W:0]    w_acc;
  logic                r_busy, r_key_accept, r_err, r_game_over;
  logic [15:0]         w_lfsr;
  logic                w_unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (w_lfsr)
  );

  // Upper LFSR bits are not consumed here.
  assign w_unused_lfsr = ^w_lfsr[15:8];

  assign w_key_ok   = key_valid && $onehot(key_dir);
  assign w_mask     = r_mask | line_done;
  assign w_scan_idx = r_start + r_k;
  assign w_scan_hit = (cell_val(board_values, w_scan_idx) == 4'd0);

  // Per-cycle merge score: sum of 2^value over flagged cells.
  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < CELLS; i++)
      if (node_score[i]) w_sum = w_sum + (SUM_W'(1) << board_values[4*i +: 4]);
  end

  assign w_acc = {1'b0, r_score} + (SCORE_W + 1)'(w_sum);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_INIT_A;
    else      r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_INIT_A, ST_INIT_B: w_next = ST_SCAN;
      ST_IDLE:   if (w_key_ok) w_next = ST_LAUNCH;
      ST_LAUNCH: w_next = ST_WAIT;
      ST_WAIT:   if (w_mask == 4'hF || r_timer == T_LAST) w_next = ST_SETTLE;
      ST_SETTLE: if (r_timer == T_ONE) w_next = (board_values != r_snap) ? ST_SCAN : ST_CHECK;
      ST_SCAN: begin
        if (w_scan_hit)          w_next = ST_WRITE;
        else if (r_k == 4'd15)   w_next = ST_CHECK;
      end
      ST_WRITE:  w_next = r_ret;
      ST_CHECK:  if (r_timer == T_ONE) w_next = (node_movable == '0) ? ST_OVER : ST_IDLE;
      ST_OVER:   w_next = ST_OVER;
      default:   w_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs; init spawns are always the small tile.
  always_comb begin
    launch_dir   = '0;
    preset_ext   = '0;
    preset_value = '0;
    if (r_state == ST_LAUNCH) launch_dir = r_dir;
    if (r_state == ST_WRITE) begin
      preset_ext   = 16'd1 << r_idx;
      preset_value = (r_ret == ST_CHECK && w_lfsr[7:4] == 4'd0) ? TILE_4 : TILE_2;
    end
  end

  // Datapath: snapshot, line mask, timers, scan cursor, score and sticky flags.
  // busy is registered from the next state so it reads 0 while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ret        <= ST_IDLE;
      r_snap       <= '0;
      r_dir        <= '0;
      r_mask       <= '0;
      r_timer      <= '0;
      r_start      <= '0;
      r_k          <= '0;
      r_idx        <= '0;
      r_score      <= '0;
      r_busy       <= 1'b0;
      r_key_accept <= 1'b0;
      r_err        <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_timer      <= (w_next != r_state) ? '0 : r_timer + T_ONE;
      r_busy       <= !(w_next == ST_IDLE || w_next == ST_OVER);
      r_key_accept <= (r_state == ST_IDLE) && w_key_ok;

      if (w_next == ST_SCAN && r_state != ST_SCAN) begin
        r_start <= w_lfsr[3:0];
        r_k     <= '0;
      end else if (r_state == ST_SCAN) begin
        r_k <= r_k + 4'd1;
      end

      unique case (r_state)
        ST_INIT_A: r_ret <= ST_INIT_B;
        ST_INIT_B: r_ret <= ST_IDLE;
        ST_IDLE: begin
          if (w_key_ok) begin
            r_snap <= board_values;
            r_dir  <= key_dir;
            r_mask <= '0;
          end
        end
        ST_WAIT: begin
          r_mask  <= w_mask;
          r_score <= w_acc[SCORE_W] ? '1 : w_acc[SCORE_W-1:0];
          if (r_timer == T_LAST && w_mask != 4'hF) r_err <= 1'b1;
        end
        ST_SETTLE: begin
          r_ret   <= ST_CHECK;
          r_score <= w_acc[SCORE_W] ? '1 : w_acc[SCORE_W-1:0];
        end
        ST_SCAN: begin
          if (w_scan_hit)        r_idx <= w_scan_idx;
          else if (r_k == 4'd15) r_err <= 1'b1;
        end
        ST_CHECK: begin
          if (r_timer == T_ONE && node_movable == '0) r_game_over <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign key_accept  = r_key_accept;
  assign score_total = r_score;
  assign busy        = r_busy;
  assign game_over   = r_game_over;
  assign err         = r_err;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed self-checking bench for move_sequencer with a minimal grid model
// that applies preset writes to the board it drives.
module tb_move_sequencer;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_dir;
  logic        key_accept;
  logic [3:0]  launch_dir;
  logic [3:0]  line_done;
  logic [63:0] board;
  logic [15:0] node_score;
  logic [15:0] node_movable;
  logic [15:0] preset_ext;
  logic [3:0]  preset_value;
  logic [19:0] score_total;
  logic        busy;
  logic        game_over;
  logic        err;

  int total = 0;
  int bad   = 0;
  int n_spawn = 0, n_accept = 0, n_launch = 0, n_badpulse = 0;
  logic [3:0] sp_idx = '0, sp_val = '0, prev_idx = '0, prev_val = '0;

  always #5 clk = ~clk;

  move_sequencer #(.SCORE_W(20), .TIMEOUT(64), .LFSR_SEED(16'hACE1)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_dir      (key_dir),
    .key_accept   (key_accept),
    .launch_dir   (launch_dir),
    .line_done    (line_done),
    .board_values (board),
    .node_score   (node_score),
    .node_movable (node_movable),
    .preset_ext   (preset_ext),
    .preset_value (preset_value),
    .score_total  (score_total),
    .busy         (busy),
    .game_over    (game_over),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock, sample 1 ns later, log pulses and apply any preset write to the board.
  task automatic tick();
    @(posedge clk);
    #1;
    if (key_accept) n_accept++;
    if (launch_dir != 4'd0) n_launch++;
    if (preset_ext != 16'd0) begin
      if (!$onehot(preset_ext)) n_badpulse++;
      prev_idx = sp_idx;
      prev_val = sp_val;
      for (int i = 0; i < 16; i++) if (preset_ext[i]) sp_idx = 4'(i);
      sp_val = preset_value;
      board[4*sp_idx +: 4] = preset_value;
      n_spawn++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; key_valid = 1'b0; key_dir = '0; line_done = '0;
    board = '0; node_score = '0; node_movable = '1;

    // Reset state
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_score", 32'(score_total), 32'd0);
    check("rst_outs", 32'({key_accept, launch_dir, preset_ext, preset_value, game_over, err}), 32'd0);

    // Start-up seeding: two distinct value-1 spawns, then idle
    rst = 1'b1;
    tick();
    check("init_busy", 32'(busy), 32'd1);
    wait_idle("init_idle");
    check("init_nspawn", 32'(n_spawn), 32'd2);
    check("init_distinct", 32'(sp_idx != prev_idx), 32'd1);
    check("init_val_a", 32'(prev_val), 32'd1);
    check("init_val_b", 32'(sp_val), 32'd1);
    check("init_onehot", 32'(n_badpulse), 32'd0);
    check("init_no_accept", 32'(n_accept), 32'd0);
    check("init_score", 32'(score_total), 32'd0);

    // Move left on row0 = {1,1,0,0}; merge into value 2 scores 4
    board = '0; board[3:0] = 4'd1; board[7:4] = 4'd1;
    n_spawn = 0; n_accept = 0; n_launch = 0;
    key_valid = 1'b1; key_dir = DIR_LEFT;
    tick();
    key_valid = 1'b0; key_dir = '0;
    check("mv_accept", 32'(key_accept), 32'd1);
    check("mv_launch", 32'(launch_dir), 32'(DIR_LEFT));
    key_valid = 1'b1; key_dir = DIR_UP;      // while busy: dropped
    tick();
    key_valid = 1'b0; key_dir = '0;
    check("mv_launch_1cyc", 32'(launch_dir), 32'd0);
    tick();
    line_done = 4'hF; board[7:0] = 8'h02; node_score = 16'h0001;
    tick();
    line_done = '0; node_score = '0;
    check("mv_score", 32'(score_total), 32'd4);
    wait_idle("mv_idle");
    check("mv_nspawn", 32'(n_spawn), 32'd1);
    check("mv_spawn_cell", 32'(sp_idx != 4'd0), 32'd1);
    check("mv_spawn_val", 32'(sp_val == 4'd1 || sp_val == 4'd2), 32'd1);
    repeat (3) tick();
    check("mv_no_queue_acc", 32'(n_accept), 32'd1);
    check("mv_no_queue_lch", 32'(n_launch), 32'd1);
    check("mv_score_hold", 32'(score_total), 32'd4);
    check("mv_err", 32'(err), 32'd0);

    // Non-one-hot direction is ignored
    n_accept = 0; n_launch = 0;
    key_valid = 1'b1; key_dir = 4'b0011;
    repeat (3) tick();
    key_valid = 1'b0; key_dir = '0;
    check("bad_dir_acc", 32'(n_accept), 32'd0);
    check("bad_dir_lch", 32'(n_launch), 32'd0);
    check("bad_dir_busy", 32'(busy), 32'd0);

    // Unchanged board: no spawn
    n_spawn = 0; n_accept = 0;
    key_valid = 1'b1; key_dir = DIR_RIGHT;
    tick();
    key_valid = 1'b0; key_dir = '0;
    check("nc_launch", 32'(launch_dir), 32'(DIR_RIGHT));
    tick();
    line_done = 4'hF;
    tick();
    line_done = '0;
    wait_idle("nc_idle");
    check("nc_nspawn", 32'(n_spawn), 32'd0);
    check("nc_accept", 32'(n_accept), 32'd1);
    check("nc_score", 32'(score_total), 32'd4);

    // Timeout: WAIT spans 64 cycles after LAUNCH, err visible on the next sample.
    // line_done during LAUNCH itself must not count.
    n_spawn = 0;
    key_valid = 1'b1; key_dir = DIR_UP;
    tick();
    key_valid = 1'b0; key_dir = '0;
    check("to_launch", 32'(launch_dir), 32'(DIR_UP));
    line_done = 4'hF;
    tick();
    line_done = '0;
    repeat (63) tick();
    check("to_err_early", 32'(err), 32'd0);
    tick();
    check("to_err", 32'(err), 32'd1);
    check("to_busy_settle", 32'(busy), 32'd1);
    wait_idle("to_idle");
    check("to_nspawn", 32'(n_spawn), 32'd0);

    // Full, immovable board -> game over, then keys are ignored
    for (int i = 0; i < 16; i++) board[4*i +: 4] = (i % 2 == 1) ? 4'd2 : 4'd1;
    node_movable = '0;
    n_spawn = 0; n_accept = 0;
    key_valid = 1'b1; key_dir = DIR_DOWN;
    tick();
    key_valid = 1'b0; key_dir = '0;
    check("go_accept", 32'(key_accept), 32'd1);
    tick();
    line_done = 4'hF;
    tick();
    line_done = '0;
    wait_idle("go_idle");
    check("go_flag", 32'(game_over), 32'd1);
    check("go_nspawn", 32'(n_spawn), 32'd0);
    check("go_err_sticky", 32'(err), 32'd1);
    n_accept = 0; n_launch = 0;
    key_valid = 1'b1; key_dir = DIR_LEFT;
    repeat (3) tick();
    key_valid = 1'b0; key_dir = '0;
    check("go_no_accept", 32'(n_accept), 32'd0);
    check("go_no_launch", 32'(n_launch), 32'd0);
    check("go_busy", 32'(busy), 32'd0);

    // Reset clears the sticky flags; reseed on an empty board
    rst = 1'b0;
    #1;
    check("rst2_outs", 32'({key_accept, launch_dir, preset_ext, preset_value, game_over, err, busy}), 32'd0);
    board = '0; node_movable = '1;
    tick();
    rst = 1'b1;
    n_spawn = 0;
    tick();
    wait_idle("rst2_idle");
    check("rst2_nspawn", 32'(n_spawn), 32'd2);

    // Saturating score (2^19 per cycle), then reset mid-WAIT
    key_valid = 1'b1; key_dir = DIR_LEFT;
    tick();
    key_valid = 1'b0; key_dir = '0;
    tick();
    board = '1; node_score = '1;
    tick();
    check("sat_step1", 32'(score_total), 32'h80000);
    tick();
    check("sat_clip", 32'(score_total), 32'hFFFFF);
    tick();
    check("sat_hold", 32'(score_total), 32'hFFFFF);
    check("sat_busy", 32'(busy), 32'd1);
    node_score = '0;
    rst = 1'b0;
    #1;
    check("rst3_score", 32'(score_total), 32'd0);
    check("rst3_outs", 32'({key_accept, launch_dir, preset_ext, preset_value, game_over, err, busy}), 32'd0);
    board = '0;
    tick();
    rst = 1'b1;
    tick();
    wait_idle("rst3_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
